// File: rtl/uc_pkg.sv
// Shared encodings for the multicycle RV32I control unit:
// FSM states, ALU codes, opcodes and datapath select values.
package uc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } uc_state_t;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0111;
    localparam logic [3:0] ALU_SLT    = 4'b0100;
    localparam logic [3:0] ALU_SLTU   = 4'b1100;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_XOR    = 4'b1001;
    localparam logic [3:0] ALU_PASS_B = 4'b0110;
    localparam logic [3:0] ALU_SLL    = 4'b1000;
    localparam logic [3:0] ALU_SRL    = 4'b1010;
    localparam logic [3:0] ALU_SRA    = 4'b1110;
    localparam logic [3:0] ALU_GE     = 4'b1011;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_REL = 2'b01;
    localparam logic [1:0] PC_SRC_REG = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [3:0] f3_alu(input logic [2:0] f3,
                                          input logic alt);
        logic [3:0] r;
        case (f3)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode/funct3/funct7[5] decode into the 4-bit
// ALU operation code plus a legality flag for the FSM.
module alu_decoder
    import uc_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic [3:0] o_alu_ctrl,
    output logic       o_legal
);

    logic w_is_sr;
    assign w_is_sr = (i_funct3 == 3'b101);

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        o_legal    = 1'b0;
        case (i_opcode)
            OP_R: begin
                o_alu_ctrl = f3_alu(i_funct3, i_funct7b5);
                o_legal    = !i_funct7b5 || i_funct3 == 3'b000 || w_is_sr;
            end
            OP_IMM: begin
                // instr[30] only matters for the shift-right pair
                o_alu_ctrl = f3_alu(i_funct3, i_funct7b5 && w_is_sr);
                o_legal    = (i_funct3 != 3'b001) || !i_funct7b5;
            end
            OP_LOAD: begin
                o_legal = (i_funct3 != 3'b011) && (i_funct3[2:1] != 2'b11);
            end
            OP_STORE: begin
                o_legal = !i_funct3[2] && (i_funct3 != 3'b011);
            end
            OP_BRANCH: begin
                o_legal = (i_funct3[2:1] != 2'b01);
                case (i_funct3)
                    3'b000, 3'b001: o_alu_ctrl = ALU_SUB;
                    3'b100:         o_alu_ctrl = ALU_SLT;
                    3'b101:         o_alu_ctrl = ALU_GE;
                    default:        o_alu_ctrl = ALU_SLTU;
                endcase
            end
            OP_LUI: begin
                o_alu_ctrl = ALU_PASS_B;
                o_legal    = 1'b1;
            end
            OP_AUIPC, OP_JAL: begin
                o_legal = 1'b1;
            end
            OP_JALR: begin
                o_legal = (i_funct3 == 3'b000);
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB(/TRAP).
// Define UC_TRAP_EN to trap on illegal instructions; else they run as NOPs.
module unidad_control_multiciclo
    import uc_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] INSTR,
    input  logic        ZERO,
    input  logic        MEM_READY,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic        MEM_ADDR_SEL,
    output logic        IR_WRITE,
    output logic        PC_WRITE,
    output logic [1:0]  PC_SRC,
    output logic        ALU_SRC_A,
    output logic        ALU_SRC_B,
    output logic [2:0]  IMM_SEL,
    output logic [3:0]  ALU_CONTROL,
    output logic        REG_WRITE,
    output logic [1:0]  WB_SEL,
    output logic        ILLEGAL
);

    uc_state_t  r_state;
    uc_state_t  w_next;
    logic [6:0] r_opcode;
    logic [2:0] r_funct3;
    logic       r_funct7b5;
    logic       r_nop;

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic       w_f7b5;
    logic [3:0] w_alu;
    logic       w_legal;
    logic       w_unused_instr;

    // DECODE judges the live bus; later states use the registered copy
    assign w_op   = (r_state == S_DECODE) ? INSTR[6:0]   : r_opcode;
    assign w_f3   = (r_state == S_DECODE) ? INSTR[14:12] : r_funct3;
    assign w_f7b5 = (r_state == S_DECODE) ? INSTR[30]    : r_funct7b5;
    assign w_unused_instr = ^{INSTR[31], INSTR[29:15], INSTR[11:7]};

    alu_decoder u_alu_dec (
        .i_opcode   (w_op),
        .i_funct3   (w_f3),
        .i_funct7b5 (w_f7b5),
        .o_alu_ctrl (w_alu),
        .o_legal    (w_legal)
    );

    logic w_is_load;
    logic w_is_store;
    logic w_is_br;
    logic w_is_jal;
    logic w_is_jalr;
    logic w_taken;
    logic w_drive;

    assign w_is_load  = (r_opcode == OP_LOAD);
    assign w_is_store = (r_opcode == OP_STORE);
    assign w_is_br    = (r_opcode == OP_BRANCH);
    assign w_is_jal   = (r_opcode == OP_JAL);
    assign w_is_jalr  = (r_opcode == OP_JALR);
    assign w_taken    = (r_funct3 == 3'b000 || r_funct3 == 3'b111)
                        ? ZERO : !ZERO;

    assign w_drive = RST_N && !r_nop &&
                     (r_state == S_EXEC || r_state == S_MEM ||
                      r_state == S_WB);

    always_comb begin
        ALU_SRC_A   = 1'b0;
        ALU_SRC_B   = 1'b0;
        IMM_SEL     = IMM_I;
        ALU_CONTROL = ALU_ADD;
        if (w_drive) begin
            ALU_SRC_A   = (r_opcode == OP_AUIPC) || w_is_jal;
            ALU_SRC_B   = !((r_opcode == OP_R) || w_is_br);
            ALU_CONTROL = w_alu;
            unique case (1'b1)
                w_is_store:                 IMM_SEL = IMM_S;
                w_is_br:                    IMM_SEL = IMM_B;
                r_opcode == OP_LUI,
                r_opcode == OP_AUIPC:       IMM_SEL = IMM_U;
                w_is_jal:                   IMM_SEL = IMM_J;
                default:                    IMM_SEL = IMM_I;
            endcase
        end
    end

    always_comb begin
        w_next       = r_state;
        MEM_REQ      = 1'b0;
        MEM_WE       = 1'b0;
        MEM_ADDR_SEL = 1'b0;
        IR_WRITE     = 1'b0;
        PC_WRITE     = 1'b0;
        PC_SRC       = PC_SRC_SEQ;
        REG_WRITE    = 1'b0;
        WB_SEL       = WB_ALU;
        if (!RST_N) begin
            w_next = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: begin
                    MEM_REQ = 1'b1;
                    if (MEM_READY) begin
                        IR_WRITE = 1'b1;
                        w_next   = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        w_next = S_EXEC;
                    end else begin
`ifdef UC_TRAP_EN
                        w_next = S_TRAP;
`else
                        w_next = S_WB;
`endif
                    end
                end
                S_EXEC: begin
                    if (w_is_br) begin
                        PC_WRITE = 1'b1;
                        PC_SRC   = w_taken ? PC_SRC_REL : PC_SRC_SEQ;
                        w_next   = S_FETCH;
                    end else if (w_is_load || w_is_store) begin
                        w_next = S_MEM;
                    end else begin
                        w_next = S_WB;
                    end
                end
                S_MEM: begin
                    MEM_REQ      = 1'b1;
                    MEM_ADDR_SEL = 1'b1;
                    MEM_WE       = w_is_store;
                    if (MEM_READY) begin
                        if (w_is_store) begin
                            PC_WRITE = 1'b1;
                            w_next   = S_FETCH;
                        end else begin
                            w_next = S_WB;
                        end
                    end
                end
                S_WB: begin
                    PC_WRITE = 1'b1;
                    w_next   = S_FETCH;
                    if (!r_nop) begin
                        REG_WRITE = 1'b1;
                        if (w_is_load)
                            WB_SEL = WB_MEM;
                        else if (w_is_jal || w_is_jalr)
                            WB_SEL = WB_PC4;
                        if (w_is_jal)
                            PC_SRC = PC_SRC_REL;
                        else if (w_is_jalr)
                            PC_SRC = PC_SRC_REG;
                    end
                end
                S_TRAP: begin
                    w_next = S_TRAP;
                end
                default: begin
                    w_next = S_FETCH;
                end
            endcase
        end
    end

`ifdef UC_TRAP_EN
    logic r_illegal;
    assign ILLEGAL = r_illegal && RST_N;
`else
    assign ILLEGAL = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= S_FETCH;
            r_opcode   <= '0;
            r_funct3   <= '0;
            r_funct7b5 <= 1'b0;
            r_nop      <= 1'b0;
`ifdef UC_TRAP_EN
            r_illegal  <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opcode   <= INSTR[6:0];
                r_funct3   <= INSTR[14:12];
                r_funct7b5 <= INSTR[30];
                r_nop      <= !w_legal;
`ifdef UC_TRAP_EN
                if (!w_legal)
                    r_illegal <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed bench: per-cycle expected output vectors queued as each
// instruction is driven, then popped and asserted cycle by cycle.
module tb_unidad_control_multiciclo;

    logic        CLK;
    logic        RST_N;
    logic [31:0] INSTR;
    logic        ZERO;
    logic        MEM_READY;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic        MEM_ADDR_SEL;
    logic        IR_WRITE;
    logic        PC_WRITE;
    logic [1:0]  PC_SRC;
    logic        ALU_SRC_A;
    logic        ALU_SRC_B;
    logic [2:0]  IMM_SEL;
    logic [3:0]  ALU_CONTROL;
    logic        REG_WRITE;
    logic [1:0]  WB_SEL;
    logic        ILLEGAL;

    unidad_control_multiciclo dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .INSTR        (INSTR),
        .ZERO         (ZERO),
        .MEM_READY    (MEM_READY),
        .MEM_REQ      (MEM_REQ),
        .MEM_WE       (MEM_WE),
        .MEM_ADDR_SEL (MEM_ADDR_SEL),
        .IR_WRITE     (IR_WRITE),
        .PC_WRITE     (PC_WRITE),
        .PC_SRC       (PC_SRC),
        .ALU_SRC_A    (ALU_SRC_A),
        .ALU_SRC_B    (ALU_SRC_B),
        .IMM_SEL      (IMM_SEL),
        .ALU_CONTROL  (ALU_CONTROL),
        .REG_WRITE    (REG_WRITE),
        .WB_SEL       (WB_SEL),
        .ILLEGAL      (ILLEGAL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic [19:0] w_obs;
    assign w_obs = {MEM_REQ, MEM_WE, MEM_ADDR_SEL, IR_WRITE, PC_WRITE,
                    PC_SRC, ALU_SRC_A, ALU_SRC_B, IMM_SEL, ALU_CONTROL,
                    REG_WRITE, WB_SEL, ILLEGAL};

    typedef struct {
        string       tag;
        logic [19:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [19:0] ov(
        input logic req, input logic we, input logic asel,
        input logic irw, input logic pcw, input logic [1:0] pcs,
        input logic a, input logic b, input logic [2:0] imm,
        input logic [3:0] alu, input logic rw, input logic [1:0] wb,
        input logic ill);
        return {req, we, asel, irw, pcw, pcs, a, b, imm, alu, rw, wb, ill};
    endfunction

    function automatic logic [19:0] fet(input logic rdy);
        return ov(H, L, L, rdy, L, 2'b00, L, L, 3'd0, 4'b0000, L, 2'b00, L);
    endfunction

    function automatic logic [19:0] ex(input logic a, input logic b,
                                       input logic [2:0] imm,
                                       input logic [3:0] alu);
        return ov(L, L, L, L, L, 2'b00, a, b, imm, alu, L, 2'b00, L);
    endfunction

    function automatic logic [19:0] wbv(input logic [1:0] pcs,
                                        input logic a, input logic b,
                                        input logic [2:0] imm,
                                        input logic [3:0] alu,
                                        input logic [1:0] wb);
        return ov(L, L, L, L, H, pcs, a, b, imm, alu, H, wb, L);
    endfunction

    task automatic push(input string tag, input logic [19:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    // drive inputs just after a rising edge, compare on the falling edge
    task automatic cyc(input logic rst_n, input logic rdy, input logic z);
        exp_t e;
        RST_N     = rst_n;
        MEM_READY = rdy;
        ZERO      = z;
        @(negedge CLK);
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty obs=%h exp=<none>", w_obs);
        end else begin
            e = sb.pop_front();
            assert (w_obs === e.v) else begin
                n_fail++;
                $error("FAIL %s obs=%h exp=%h", e.tag, w_obs, e.v);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic r_type(input string t, input logic [31:0] ins,
                          input logic [3:0] alu);
        INSTR = ins;
        push({t, "_fetch"}, fet(H));
        push({t, "_dec"},   '0);
        push({t, "_exec"},  ex(L, L, 3'd0, alu));
        push({t, "_wb"},    wbv(2'b00, L, L, 3'd0, alu, 2'b00));
        repeat (4) cyc(H, H, L);
    endtask

    initial begin
        RST_N     = 1'b0;
        INSTR     = '0;
        ZERO      = 1'b0;
        MEM_READY = 1'b1;
        @(posedge CLK);
        #1;
        push("rst0", '0);
        cyc(L, H, L);
        push("rst1", '0);
        cyc(L, H, L);

        r_type("add", 32'h002081B3, 4'b0000);
        r_type("sra", 32'h4020D1B3, 4'b1110);

        INSTR = 32'h00000463;
        push("beq_t_fetch", fet(H));
        push("beq_t_dec",   '0);
        push("beq_t_exec",
             ov(L, L, L, L, H, 2'b01, L, L, 3'd2, 4'b0111, L, 2'b00, L));
        repeat (3) cyc(H, H, H);
        push("beq_n_fetch", fet(H));
        push("beq_n_dec",   '0);
        push("beq_n_exec",
             ov(L, L, L, L, H, 2'b00, L, L, 3'd2, 4'b0111, L, 2'b00, L));
        repeat (3) cyc(H, H, L);

        INSTR = 32'h0020C463;
        push("blt_fetch", fet(H));
        push("blt_dec",   '0);
        push("blt_exec",
             ov(L, L, L, L, H, 2'b01, L, L, 3'd2, 4'b0100, L, 2'b00, L));
        repeat (3) cyc(H, H, L);

        INSTR = 32'h00002283;
        push("lw_fetch", fet(H));
        push("lw_dec",   '0);
        push("lw_exec",  ex(L, H, 3'd0, 4'b0000));
        for (int i = 0; i < 3; i++)
            push("lw_mem",
                 ov(H, L, H, L, L, 2'b00, L, H, 3'd0, 4'b0000, L, 2'b00, L));
        push("lw_wb", wbv(2'b00, L, H, 3'd0, 4'b0000, 2'b01));
        cyc(H, H, L);
        cyc(H, H, L);
        cyc(H, H, L);
        cyc(H, L, L);
        cyc(H, L, L);
        cyc(H, H, L);
        cyc(H, H, L);

        INSTR = 32'h00502223;
        push("sw_fetch", fet(H));
        push("sw_dec",   '0);
        push("sw_exec",  ex(L, H, 3'd1, 4'b0000));
        push("sw_mem",
             ov(H, H, H, L, H, 2'b00, L, H, 3'd1, 4'b0000, L, 2'b00, L));
        repeat (4) cyc(H, H, L);

        push("swr_fetch_wait", fet(L));
        push("swr_fetch", fet(H));
        push("swr_dec",   '0);
        push("swr_exec",  ex(L, H, 3'd1, 4'b0000));
        push("swr_mem_wait",
             ov(H, H, H, L, L, 2'b00, L, H, 3'd1, 4'b0000, L, 2'b00, L));
        push("swr_in_rst",  '0);
        push("swr_refetch", fet(L));
        cyc(H, L, L);
        cyc(H, H, L);
        cyc(H, H, L);
        cyc(H, H, L);
        cyc(H, L, L);
        cyc(L, H, L);
        cyc(H, L, L);

        INSTR = 32'h123450B7;
        push("lui_fetch", fet(H));
        push("lui_dec",   '0);
        push("lui_exec",  ex(L, H, 3'd3, 4'b0110));
        push("lui_wb",    wbv(2'b00, L, H, 3'd3, 4'b0110, 2'b00));
        repeat (4) cyc(H, H, L);

        INSTR = 32'h008000EF;
        push("jal_fetch", fet(H));
        push("jal_dec",   '0);
        push("jal_exec",  ex(H, H, 3'd4, 4'b0000));
        push("jal_wb",    wbv(2'b01, H, H, 3'd4, 4'b0000, 2'b10));
        repeat (4) cyc(H, H, L);

        INSTR = 32'h000100E7;
        push("jalr_fetch", fet(H));
        push("jalr_dec",   '0);
        push("jalr_exec",  ex(L, H, 3'd0, 4'b0000));
        push("jalr_wb",    wbv(2'b10, L, H, 3'd0, 4'b0000, 2'b10));
        repeat (4) cyc(H, H, L);

        INSTR = 32'hFFFFFFFF;
        push("ill_fetch", fet(H));
        push("ill_dec",   '0);
`ifdef UC_TRAP_EN
        push("ill_trap0",
             ov(L, L, L, L, L, 2'b00, L, L, 3'd0, 4'b0000, L, 2'b00, H));
        push("ill_trap1",
             ov(L, L, L, L, L, 2'b00, L, L, 3'd0, 4'b0000, L, 2'b00, H));
        push("ill_trap2",
             ov(L, L, L, L, L, 2'b00, L, L, 3'd0, 4'b0000, L, 2'b00, H));
        repeat (5) cyc(H, H, L);
        push("ill_rst", '0);
        cyc(L, H, L);
`else
        push("ill_nop",
             ov(L, L, L, L, H, 2'b00, L, L, 3'd0, 4'b0000, L, 2'b00, L));
        repeat (3) cyc(H, H, L);
`endif

        r_type("add2", 32'h002081B3, 4'b0000);

        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain obs=%0d exp=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/unidad_control_multiciclo.md
# unidad_control_multiciclo

- Multicycle RV32I control unit; the other end of the ALU's `CONTROL`/`ZERO` interface.
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Drives the datapath selects, the memory request handshake and the 4-bit ALU operation code.
- Sits between the instruction register/memory port and the register file/ALU datapath.

## Interface
- No parameters.
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: synchronous, active-low reset.
- `INSTR` in 32: current instruction word from the memory read bus, captured when `IR_WRITE`=1.
- `ZERO` in 1: ALU zero flag, sampled in EXEC for branches.
- `MEM_READY` in 1: memory accepts/completes the current request this cycle.
- `MEM_REQ` out 1: memory request.
- `MEM_WE` out 1: store request.
- `MEM_ADDR_SEL` out 1: memory address source; 0 = PC, 1 = ALU result.
- `IR_WRITE` out 1: load the instruction register.
- `PC_WRITE` out 1: update PC.
- `PC_SRC` out 2: next-PC source; 00 = PC+4, 01 = PC+immB/immJ, 10 = (rs1+immI)&~1.
- `ALU_SRC_A` out 1: ALU operand A; 0 = rs1, 1 = PC.
- `ALU_SRC_B` out 1: ALU operand B; 0 = rs2, 1 = immediate.
- `IMM_SEL` out 3: immediate format; 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- `ALU_CONTROL` out 4: ALU operation code.
- `REG_WRITE` out 1: register-file write enable.
- `WB_SEL` out 2: write-back source; 00 = ALU, 01 = memory, 10 = PC+4.
- `ILLEGAL` out 1: sticky illegal-instruction flag.

## Operation
- **ALU codes:**
  - ADD 0000, SUB 0111, SLT 0100, SLTU 1100.
  - AND 0010, OR 0001, XOR 1001, PASS_B 0110.
  - SLL 1000, SRL 1010, SRA 1110, GE 1011.
- **Opcode/funct to ALU code:**
  - R-type and I-type use funct3, plus funct7[5] for SUB/SRA.
  - SRAI uses instr[30].
  - Loads, stores, AUIPC, JALR use ADD; LUI uses PASS_B.
- **States:** FETCH, DECODE, EXEC, MEM, WB, TRAP; encoded in the package enum.
- **FETCH**
  - Outputs: `MEM_REQ`=1, `MEM_ADDR_SEL`=0.
  - Holds until `MEM_READY`=1; that cycle `IR_WRITE`=1, then go to DECODE.
- **DECODE**
  - Registers opcode, funct3 and funct7[5].
  - Illegal opcode/funct combination goes to TRAP; everything else goes to EXEC.
- **EXEC**
  - Drives ALU selects and code.
  - R/I/LUI/AUIPC/JAL/JALR go to WB.
  - Load/store go to MEM.
  - Branch: `PC_WRITE`=1, then go to FETCH.
    - `PC_SRC`=01 if taken, 00 otherwise.
    - Taken when BEQ/BGEU and `ZERO`=1, or BNE/BLT/BGE/BLTU and `ZERO`=0.
    - BGE uses GE; BGEU uses SLTU.
- **MEM**
  - Outputs: `MEM_REQ`=1, `MEM_ADDR_SEL`=1, `MEM_WE`=1 for stores; ALU selects and code held stable.
  - On `MEM_READY`: a load goes to WB; a store sets `PC_WRITE`=1 with `PC_SRC`=00 and goes to FETCH.
- **WB**
  - Outputs: `REG_WRITE`=1, `PC_WRITE`=1, then go to FETCH.
  - `WB_SEL`: 01 for loads, 10 for JAL/JALR, 00 otherwise.
  - `PC_SRC`: 01 for JAL, 10 for JALR, 00 otherwise.
  - rd=x0 is still written; the register file ignores it.
- **Outside active states:** every output is 0.
- **`ILLEGAL`** is the only registered output; all others are decoded from the state and the registered instruction fields.

## Timing
- **Reset:**
  - `RST_N`=0 sampled on an edge: state = FETCH, `ILLEGAL`=0, decoded fields cleared.
  - All outputs are 0 while `RST_N`=0, including `MEM_REQ`.
  - Reset during a MEM/FETCH wait abandons the request; no `PC_WRITE`/`REG_WRITE` occurs.
- **Latency with zero memory wait:**
  - Branch: 3 cycles.
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle adds 1.
- **Memory handshake:**
  - `MEM_REQ`, `MEM_WE` and `MEM_ADDR_SEL` stay stable until `MEM_READY`=1 is sampled.
  - Exactly one transfer per request.
  - `MEM_READY` outside FETCH/MEM is ignored.
- **Write pulses:** `PC_WRITE` and `REG_WRITE` are high for exactly one cycle per instruction; `PC_WRITE` is never high in FETCH/DECODE.

## Configuration
- Macro: `UC_TRAP_EN`.
- **Defined:**
  - Illegal instruction goes DECODE → TRAP.
  - `ILLEGAL`=1 from the next cycle.
  - TRAP holds all other outputs 0 until reset.
- **Undefined:**
  - Illegal instruction goes DECODE → WB with `REG_WRITE`=0, `PC_WRITE`=1, `PC_SRC`=00 (executes as a NOP).
  - `ILLEGAL` stays tied 0; TRAP is unreachable.

## Structure
- Package `uc_pkg`:
  - State enum.
  - ALU code localparams.
  - RV32I opcode constants.
  - `PC_SRC`/`WB_SEL`/`IMM_SEL` encodings.
- Sub-module `alu_decoder`: combinational opcode/funct3/funct7[5] → `ALU_CONTROL` plus a legality bit.

## Test plan
- **ADD** x3,x1,x2 (0x002081B3), `MEM_READY` tied 1:
  - `IR_WRITE` in cycle 0; `ALU_CONTROL`=0000 with `ALU_SRC_B`=0 in cycle 2.
  - Cycle 3: `REG_WRITE`=1, `WB_SEL`=00, `PC_WRITE`=1, `PC_SRC`=00.
- **SRA** x3,x1,x2 (0x4020D1B3): `ALU_CONTROL`=1110 in EXEC.
- **BEQ** x0,x0,+8 (0x00000463):
  - `ZERO`=1 → EXEC `PC_WRITE`=1, `PC_SRC`=01, 3 cycles total, no `REG_WRITE`.
  - `ZERO`=0 → `PC_SRC`=00.
- **LW** x5,0(x0) (0x00002283) with 2 wait cycles in MEM:
  - `MEM_REQ`=1, `MEM_ADDR_SEL`=1 held for 3 cycles.
  - Then WB with `WB_SEL`=01; 7 cycles total.
- **SW** x5,4(x0) (0x00502223):
  - MEM `MEM_WE`=1, `IMM_SEL`=1, `ALU_CONTROL`=0000; no `REG_WRITE`.
  - `RST_N`=0 during its MEM wait → next cycle all outputs 0, state FETCH.
- **Illegal** 0xFFFFFFFF:
  - With `UC_TRAP_EN`: `ILLEGAL`=1 and no further `MEM_REQ`.
  - Without: NOP, `PC_WRITE` with `PC_SRC`=00, next FETCH issued.
